// File: rtl/stopwatch_bcd_counter_if.sv
// Control and display bundle between the stopwatch time base and its neighbours.
// The master side drives ticks and controls; the slave side (the counter) drives the digits.
interface stopwatch_bcd_counter_if;
  logic       i_tick_1hz;
  logic       i_tick_2hz;
  logic       i_pause;
  logic       i_adj;
  logic       i_sel;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] dig4;
  logic       o_paused;
  logic       o_adjusting;

  modport master (
    output i_tick_1hz, i_tick_2hz, i_pause, i_adj, i_sel,
    input  dig1, dig2, dig3, dig4, o_paused, o_adjusting
  );

  modport slave (
    input  i_tick_1hz, i_tick_2hz, i_pause, i_adj, i_sel,
    output dig1, dig2, dig3, dig4, o_paused, o_adjusting
  );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// mm:ss BCD stopwatch time base with run, pause and manual adjust of either field.
// Define STOPWATCH_BLINK_EN to blank the field being adjusted on alternate 2 Hz phases.
module stopwatch_bcd_counter #(
  parameter int MAX_MIN      = 59,
  parameter int MAX_SEC      = 59,
  parameter bit RESET_PAUSED = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  stopwatch_bcd_counter_if.slave  bus
);

  typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_ADJUST} state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

  localparam bcd_pair_t SEC_MAX = '{tens: 4'(MAX_SEC / 10), ones: 4'(MAX_SEC % 10)};
  localparam bcd_pair_t MIN_MAX = '{tens: 4'(MAX_MIN / 10), ones: 4'(MAX_MIN % 10)};

  // Increment a BCD pair, wrapping to 00 once the field's maximum is reached.
  function automatic bcd_pair_t bcd_inc(bcd_pair_t v, bcd_pair_t max_v);
    bcd_pair_t r;
    if (v == max_v) begin
      r = '0;
    end else if (v.ones == 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = v.tens;
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  state_t    state_q, state_d;
  logic      paused_q, paused_d;
  logic      adjusting_q;
  bcd_pair_t sec_q, sec_d;
  bcd_pair_t min_q, min_d;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    sec_d    = sec_q;
    min_d    = min_q;

    // The pause flag toggles in every state; outside ADJUST it also picks RUN vs PAUSED.
    if (bus.i_pause) paused_d = ~paused_q;

    case (state_q)
      ST_RUN, ST_PAUSED: begin
        if (state_q == ST_RUN && bus.i_tick_1hz) begin
          sec_d = bcd_inc(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX) min_d = bcd_inc(min_q, MIN_MAX);
        end
        if (bus.i_adj) state_d = ST_ADJUST;
        else           state_d = paused_d ? ST_PAUSED : ST_RUN;
      end
      ST_ADJUST: begin
        if (bus.i_tick_2hz) begin
          if (bus.i_sel) sec_d = bcd_inc(sec_q, SEC_MAX);
          else           min_d = bcd_inc(min_q, MIN_MAX);
        end
        if (!bus.i_adj) state_d = paused_d ? ST_PAUSED : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= RESET_PAUSED ? ST_PAUSED : ST_RUN;
      paused_q    <= RESET_PAUSED;
      adjusting_q <= 1'b0;
      sec_q       <= '0;
      min_q       <= '0;
    end else begin
      state_q     <= state_d;
      paused_q    <= paused_d;
      adjusting_q <= (state_d == ST_ADJUST);
      sec_q       <= sec_d;
      min_q       <= min_d;
    end
  end

  assign bus.o_paused    = paused_q;
  assign bus.o_adjusting = adjusting_q;

`ifdef STOPWATCH_BLINK_EN
  logic      phase_q, phase_d;
  logic      blank_sec, blank_min;
  bcd_pair_t sec_disp_q, min_disp_q;

  // Phase restarts at 0 on ADJUST entry so the first adjust step is always blanked.
  always_comb begin
    phase_d   = phase_q ^ bus.i_tick_2hz;
    if (state_q != ST_ADJUST && state_d == ST_ADJUST) phase_d = 1'b0;
    blank_sec = (state_d == ST_ADJUST) && phase_d &&  bus.i_sel;
    blank_min = (state_d == ST_ADJUST) && phase_d && !bus.i_sel;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      phase_q    <= 1'b0;
      sec_disp_q <= '0;
      min_disp_q <= '0;
    end else begin
      phase_q    <= phase_d;
      sec_disp_q <= blank_sec ? 8'hFF : sec_d;
      min_disp_q <= blank_min ? 8'hFF : min_d;
    end
  end

  assign bus.dig1 = sec_disp_q.ones;
  assign bus.dig2 = sec_disp_q.tens;
  assign bus.dig3 = min_disp_q.ones;
  assign bus.dig4 = min_disp_q.tens;
`else
  assign bus.dig1 = sec_q.ones;
  assign bus.dig2 = sec_q.tens;
  assign bus.dig3 = min_q.ones;
  assign bus.dig4 = min_q.tens;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench for stopwatch_bcd_counter: a time-in-seconds reference model predicts every
// cycle's outputs; directed sequences plus randomized stimulus exercise run, pause, adjust and reset.
module tb_stopwatch_bcd_counter;
  localparam int MAX_MIN      = 59;
  localparam int MAX_SEC      = 59;
  localparam bit RESET_PAUSED = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stopwatch_bcd_counter_if bus();

  stopwatch_bcd_counter #(
    .MAX_MIN      (MAX_MIN),
    .MAX_SEC      (MAX_SEC),
    .RESET_PAUSED (RESET_PAUSED)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic        paused;
    logic        adjusting;
  } obs_t;

  typedef enum {M_RUN, M_PAUSED, M_ADJUST} mode_t;

  obs_t  exp_q[$];
  obs_t  exp_o;
  int    n_checks = 0;
  int    n_fail   = 0;

  mode_t m_mode;
  int    m_sec, m_min;
  bit    m_paused, m_phase;
  bit    lvl_rst, lvl_adj, lvl_sel;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // Reference model: time kept as plain integers, advanced one edge at a time.
  task automatic model_step(bit r, bit t1, bit t2, bit p, bit a, bit s);
    mode_t      old;
    int         total;
    logic [7:0] sec_disp, min_disp;
    obs_t       o;
    if (!r) begin
      m_sec    = 0;
      m_min    = 0;
      m_paused = RESET_PAUSED;
      m_mode   = RESET_PAUSED ? M_PAUSED : M_RUN;
      m_phase  = 1'b0;
    end else begin
      old = m_mode;
      if (old == M_RUN && t1) begin
        total = (m_min * (MAX_SEC + 1) + m_sec + 1) % ((MAX_MIN + 1) * (MAX_SEC + 1));
        m_min = total / (MAX_SEC + 1);
        m_sec = total % (MAX_SEC + 1);
      end
      if (old == M_ADJUST && t2) begin
        if (s) m_sec = (m_sec + 1) % (MAX_SEC + 1);
        else   m_min = (m_min + 1) % (MAX_MIN + 1);
      end
      if (p) m_paused = !m_paused;
      m_mode = a ? M_ADJUST : (m_paused ? M_PAUSED : M_RUN);
      if (old != M_ADJUST && m_mode == M_ADJUST) m_phase = 1'b0;
      else if (t2)                               m_phase = !m_phase;
    end
    sec_disp = to_bcd(m_sec);
    min_disp = to_bcd(m_min);
`ifdef STOPWATCH_BLINK_EN
    if (m_mode == M_ADJUST && m_phase) begin
      if (s) sec_disp = 8'hFF;
      else   min_disp = 8'hFF;
    end
`endif
    o.digits    = {min_disp, sec_disp};
    o.paused    = m_paused;
    o.adjusting = (m_mode == M_ADJUST);
    exp_q.push_back(o);
  endtask

  // One clock of stimulus: pulses given as arguments, levels taken from lvl_*.
  task automatic step(bit t1, bit t2, bit p);
    @(negedge clk);
    rst            = lvl_rst;
    bus.i_tick_1hz = t1;
    bus.i_tick_2hz = t2;
    bus.i_pause    = p;
    bus.i_adj      = lvl_adj;
    bus.i_sel      = lvl_sel;
    @(posedge clk);
    model_step(lvl_rst, t1, t2, p, lvl_adj, lvl_sel);
    #1;
  endtask

  task automatic check_disp(string name, logic [15:0] d);
    check(name, 32'({bus.dig4, bus.dig3, bus.dig2, bus.dig1}), 32'(d));
  endtask

  task automatic check_flags(string name, bit p, bit a);
    check(name, 32'({bus.o_paused, bus.o_adjusting}), 32'({p, a}));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_o = exp_q.pop_front();
      check("scoreboard",
            32'({bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.o_paused, bus.o_adjusting}),
            32'(exp_o));
    end
  end

  initial begin
    bus.i_tick_1hz = 1'b0;
    bus.i_tick_2hz = 1'b0;
    bus.i_pause    = 1'b0;
    bus.i_adj      = 1'b0;
    bus.i_sel      = 1'b0;
    lvl_rst = 1'b0;
    lvl_adj = 1'b0;
    lvl_sel = 1'b0;

    // Reset state
    step(0, 0, 0);
    step(0, 0, 0);
    check_disp("reset_digits", 16'h0000);
    check_flags("reset_flags", RESET_PAUSED, 1'b0);
    lvl_rst = 1'b1;

    // 61 seconds -> 01:01
    repeat (61) step(1, 0, 0);
    check_disp("count_61", 16'h0101);
    check_flags("count_61_flags", 1'b0, 1'b0);

    // Preload 59:58 through adjust, then roll over to 00:00
    lvl_rst = 1'b0; step(0, 0, 0); lvl_rst = 1'b1;
    lvl_adj = 1'b1; lvl_sel = 1'b0;
    step(0, 0, 0);
    check_flags("adjust_entry", 1'b0, 1'b1);
    repeat (59) step(0, 1, 0);
    lvl_sel = 1'b1;
    repeat (58) step(0, 1, 0);
    lvl_adj = 1'b0;
    step(0, 0, 0);
    check_disp("preload_5958", 16'h5958);
    step(1, 0, 0);
    step(1, 0, 0);
    check_disp("full_wrap", 16'h0000);

    // Pause holds the count; resume continues it
    repeat (5) step(1, 0, 0);
    check_disp("run_0005", 16'h0005);
    step(0, 0, 1);
    repeat (3) step(1, 0, 0);
    check_disp("paused_hold", 16'h0005);
    check_flags("paused_flag", 1'b1, 1'b0);
    step(0, 0, 1);
    step(1, 0, 0);
    check_disp("resumed", 16'h0006);
    check_flags("resumed_flag", 1'b0, 1'b0);

    // Tick on the adjust-rise edge counts under RUN; seconds wrap with no carry
    lvl_adj = 1'b1; lvl_sel = 1'b1;
    step(1, 0, 0);
    check_disp("tick_on_adj_rise", 16'h0007);
    repeat (51) step(0, 1, 0);
    repeat (3)  step(0, 1, 0);
`ifndef STOPWATCH_BLINK_EN
    check_disp("sec_wrap_no_carry", 16'h0001);
`endif
    lvl_sel = 1'b0;
    repeat (2) step(0, 1, 0);
    lvl_adj = 1'b0;
    step(0, 0, 0);
    check_disp("adjust_min_0201", 16'h0201);

    // Pause inside ADJUST, then release: lands in PAUSED, release-edge tick ignored
    lvl_adj = 1'b1;
    step(0, 0, 0);
    step(0, 0, 1);
    check_flags("pause_in_adjust", 1'b1, 1'b1);
    lvl_adj = 1'b0;
    step(1, 0, 0);
    check_disp("release_tick_ignored", 16'h0201);
    check_flags("release_to_paused", 1'b1, 1'b0);
    step(1, 0, 0);
    check_disp("still_paused", 16'h0201);

    // Reset mid-count at 12:34
    step(0, 0, 1);
    lvl_adj = 1'b1; lvl_sel = 1'b0;
    step(0, 0, 0);
    repeat (10) step(0, 1, 0);
    lvl_sel = 1'b1;
    repeat (33) step(0, 1, 0);
    lvl_adj = 1'b0;
    step(0, 0, 0);
    check_disp("preload_1234", 16'h1234);
    lvl_rst = 1'b0;
    step(1, 0, 0);
    check_disp("reset_mid_count", 16'h0000);
    check_flags("reset_mid_flags", RESET_PAUSED, 1'b0);
    lvl_rst = 1'b1;

`ifdef STOPWATCH_BLINK_EN
    lvl_adj = 1'b1; lvl_sel = 1'b1;
    step(0, 0, 0);
    step(0, 1, 0);
    check("blink_on", 32'({bus.dig2, bus.dig1}), 32'h0000_00FF);
    step(0, 1, 0);
    check("blink_off", 32'({bus.dig2, bus.dig1}), 32'h0000_0002);
    lvl_adj = 1'b0;
    step(0, 0, 0);
`endif

    // Randomized traffic against the model
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) lvl_adj = ~lvl_adj;
      if ($urandom_range(0, 9) == 0)  lvl_sel = ~lvl_sel;
      lvl_rst = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 15) == 0);
    end
    lvl_rst = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Mm:ss stopwatch time base that sits directly upstream of the four-digit seven-segment driver.
- Produces four BCD digits on dig1..dig4 (dig1 = rightmost) and supports run, pause and manual adjust of minutes or seconds.
- Counts on single-cycle tick pulses generated by the shared clock divider.
- Pause input is already debounced and edge-detected upstream.

Parameters:
- MAX_MIN, 59, highest minutes value before wrap to 0 (legal range 1..99).
- MAX_SEC, 59, highest seconds value before wrap to 0 (legal range 1..99).
- RESET_PAUSED, 0, when 1 the block leaves reset in PAUSED instead of RUN.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous, active-low.
- i_tick_1hz  input  1  one-cycle count pulse.
- i_tick_2hz  input  1  one-cycle adjust-rate pulse.
- i_pause  input  1  one-cycle pause/resume toggle request.
- i_adj  input  1  level; 1 = adjust mode.
- i_sel  input  1  level; 0 = adjust minutes, 1 = adjust seconds.
- dig1  output  4  seconds ones, BCD.
- dig2  output  4  seconds tens, BCD.
- dig3  output  4  minutes ones, BCD.
- dig4  output  4  minutes tens, BCD.
- o_paused  output  1  stored pause flag.
- o_adjusting  output  1  high while in ADJUST.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - All digits 0.
  - o_adjusting=0.
  - o_paused=RESET_PAUSED; state RUN or PAUSED accordingly.
  - Reset has priority over every other input.
- All outputs are registered. Each action is decided by the state register value at the start of the cycle, and its effect is visible one cycle after the triggering input.
- States: RUN, PAUSED, ADJUST. The pause flag register is kept separately.
- Transitions:
  - RUN + i_pause -> PAUSED, pause flag set.
  - PAUSED + i_pause -> RUN, pause flag cleared.
  - RUN/PAUSED + i_adj=1 -> ADJUST.
  - ADJUST + i_adj=0 -> RUN if pause flag=0, else PAUSED.
  - i_pause in ADJUST toggles the pause flag only; the state stays ADJUST.
- RUN counting on i_tick_1hz:
  - Seconds +1.
  - At MAX_SEC, seconds -> 0 and minutes +1.
  - At MAX_SEC with minutes at MAX_MIN, the display wraps to 00:00.
  - Ticks are ignored in PAUSED and ADJUST.
- ADJUST on i_tick_2hz: the field chosen by i_sel (sampled the same cycle) increments by 1.
  - Wraps MAX->0 with no carry into the other field.
  - i_tick_1hz is ignored in ADJUST.
- Arithmetic is carried out directly on BCD digit pairs (ones 9->0 carries into tens).
  - Digits outside 0..9 are never produced, except the blank code under BLINK_EN.
- Simultaneous events:
  - Tick with i_pause in RUN: the count is applied and the state goes to PAUSED in the same edge.
  - Tick with the i_adj rise: the tick is handled under the old state.
  - i_sel changing mid-ADJUST takes effect on the next i_tick_2hz.
- Reset mid-count or mid-adjust clears everything on that edge. No partial update.

Optional Feature:
- Macro: STOPWATCH_BLINK_EN.
- Defined:
  - A blink phase register toggles on each i_tick_2hz and is forced to 0 on reset and on ADJUST entry.
  - In ADJUST with phase=1, both digits of the selected field output 4'hF, which the downstream decoder blanks.
  - Internal count values are unaffected.
  - Digits return to true values the cycle after ADJUST exit.
- Undefined: no phase register; digits always show true values.

Test Plan:
- Reset then 61 i_tick_1hz pulses -> dig4..dig1 = 0,1,0,1; o_paused=0.
- Preload to 59:58 via adjust, release i_adj, then 2 i_tick_1hz -> 00:00.
- In RUN at 00:05: i_pause, then 3 i_tick_1hz -> still 00:05, o_paused=1; second i_pause plus 1 tick -> 00:06.
- i_adj=1, i_sel=1 at 00:58, then 3 i_tick_2hz -> 00:01, minutes unchanged; i_sel=0 then 2 i_tick_2hz -> 02:01.
- In ADJUST with a pause pulse, drop i_adj -> PAUSED, o_paused=1; a 1 Hz tick on the i_adj-release edge is ignored.
- Hold i_rst=0 while count is 12:34 in RUN -> all digits 0 the next edge; with STOPWATCH_BLINK_EN in ADJUST/i_sel=1, alternate 2 Hz ticks show dig1=dig2=4'hF.
